// File: rtl/alu_share_arbiter_if.sv
// Requester-side and ALU-side bus of the shared-ALU arbiter.
//   slave  : arbiter view (drives ready/response/ALU inputs, reads requests/result)
//   master : requester + ALU view (drives requests/response-ready/result)
//   req_*      : per-requester packed request fields and handshake
//   resp_*     : per-requester response handshake and shared result/error
//   alu_*      : single ALU enable, opcode, operands and returned result
interface alu_share_arbiter_if #(
   parameter int unsigned NUM_REQ = 4
);
   logic [NUM_REQ-1:0]   req_valid_in;
   logic [NUM_REQ-1:0]   req_ready_out;
   logic [3*NUM_REQ-1:0] req_opcode_in;
   logic [8*NUM_REQ-1:0] req_a_in;
   logic [8*NUM_REQ-1:0] req_b_in;
   logic [NUM_REQ-1:0]   resp_valid_out;
   logic [NUM_REQ-1:0]   resp_ready_in;
   logic [7:0]           resp_data_out;
   logic                 resp_error_out;
   logic                 alu_enable_out;
   logic [2:0]           alu_opcode_out;
   logic [7:0]           alu_input1_out;
   logic [7:0]           alu_input2_out;
   logic [7:0]           alu_result_in;

   modport slave (
      input  req_valid_in, req_opcode_in, req_a_in, req_b_in, resp_ready_in, alu_result_in,
      output req_ready_out, resp_valid_out, resp_data_out, resp_error_out,
             alu_enable_out, alu_opcode_out, alu_input1_out, alu_input2_out
   );

   modport master (
      output req_valid_in, req_opcode_in, req_a_in, req_b_in, resp_ready_in, alu_result_in,
      input  req_ready_out, resp_valid_out, resp_data_out, resp_error_out,
             alu_enable_out, alu_opcode_out, alu_input1_out, alu_input2_out
   );
endinterface

// File: rtl/alu_share_arbiter.sv
// Shares a single fixed-latency ALU between NUM_REQ requesters with
// round-robin arbitration, operand latching and a response handshake.
//   clock_in : system clock, rising edge
//   reset_in : asynchronous active-low reset
//   bus      : request/response/ALU signals (alu_share_arbiter_if.slave)
//   busy_out : high whenever an operation is in flight or awaiting response
module alu_share_arbiter #(
   parameter int unsigned NUM_REQ     = 4,
   parameter int unsigned ALU_LATENCY = 2
) (
   input  logic               clock_in,
   input  logic               reset_in,
   alu_share_arbiter_if.slave bus,
   output logic               busy_out
);

   localparam int unsigned IDX_W   = $clog2(NUM_REQ);
   localparam int unsigned CNT_W   = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;
   localparam logic [2:0]  OPC_MAX = 3'd4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   ptr_q,   ptr_d;
   logic [IDX_W-1:0]   gnt_q,   gnt_d;
   logic [2:0]         opc_q,   opc_d;
   logic [7:0]         a_q,     a_d;
   logic [7:0]         b_q,     b_d;
   logic [7:0]         res_q,   res_d;
   logic               err_q,   err_d;
   logic [CNT_W-1:0]   cnt_q,   cnt_d;

   logic [2:0]         opc_arr [NUM_REQ];
   logic [7:0]         a_arr   [NUM_REQ];
   logic [7:0]         b_arr   [NUM_REQ];
   logic               win_found_c;
   logic [IDX_W-1:0]   win_idx_c;
   int unsigned        cand;

   // Unpack the flat per-requester request fields.
   always_comb begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         opc_arr[i] = bus.req_opcode_in[3*i +: 3];
         a_arr[i]   = bus.req_a_in[8*i +: 8];
         b_arr[i]   = bus.req_b_in[8*i +: 8];
      end
   end

   // Round-robin search: first valid requester at or above the pointer, wrapping.
   always_comb begin
      win_found_c = 1'b0;
      win_idx_c   = '0;
      cand        = 0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         cand = (32'(ptr_q) + i) % NUM_REQ;
         if (!win_found_c && bus.req_valid_in[IDX_W'(cand)]) begin
            win_found_c = 1'b1;
            win_idx_c   = IDX_W'(cand);
         end
      end
   end

   // State and datapath registers.
   always_ff @(posedge clock_in or negedge reset_in) begin
      if (!reset_in) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         gnt_q   <= '0;
         opc_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gnt_q   <= gnt_d;
         opc_q   <= opc_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state and output decode.
   always_comb begin
      state_d            = state_q;
      ptr_d              = ptr_q;
      gnt_d              = gnt_q;
      opc_d              = opc_q;
      a_d                = a_q;
      b_d                = b_q;
      res_d              = res_q;
      err_d              = err_q;
      cnt_d              = cnt_q;

      bus.req_ready_out  = '0;
      bus.resp_valid_out = '0;
      bus.resp_data_out  = '0;
      bus.resp_error_out = 1'b0;
      bus.alu_enable_out = 1'b0;
      bus.alu_opcode_out = '0;
      bus.alu_input1_out = '0;
      bus.alu_input2_out = '0;
      busy_out           = (state_q != ST_IDLE);

      unique case (state_q)
         ST_IDLE: begin
            // Ready is gated by reset so nothing handshakes while reset is held.
            if (win_found_c && reset_in) begin
               bus.req_ready_out[win_idx_c] = 1'b1;
               gnt_d = win_idx_c;
               opc_d = opc_arr[win_idx_c];
               a_d   = a_arr[win_idx_c];
               b_d   = b_arr[win_idx_c];
               if (opc_arr[win_idx_c] <= OPC_MAX) begin
                  state_d = ST_EXEC;
                  cnt_d   = CNT_W'(ALU_LATENCY - 1);
                  err_d   = 1'b0;
               end else begin
                  // Illegal opcode skips the ALU entirely.
                  state_d = ST_RESP;
                  res_d   = '0;
                  err_d   = 1'b1;
               end
            end
         end

         ST_EXEC: begin
            bus.alu_enable_out = 1'b1;
            bus.alu_opcode_out = opc_q;
            bus.alu_input1_out = a_q;
            bus.alu_input2_out = b_q;
            if (cnt_q == '0) begin
               res_d   = bus.alu_result_in;
               state_d = ST_RESP;
            end else begin
               cnt_d   = cnt_q - CNT_W'(1);
            end
         end

         ST_RESP: begin
            bus.resp_valid_out[gnt_q] = 1'b1;
            bus.resp_data_out         = res_q;
            bus.resp_error_out        = err_q;
            if (bus.resp_ready_in[gnt_q]) begin
               state_d = ST_IDLE;
               err_d   = 1'b0;
               ptr_d   = (gnt_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_q + IDX_W'(1);
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed scoreboard bench for alu_share_arbiter with a 2-cycle ALU stub.
module tb_alu_share_arbiter;

   localparam int unsigned NR = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic busy_out;
   int   cyc = 0;

   alu_share_arbiter_if #(.NUM_REQ(NR)) bus ();

   alu_share_arbiter #(.NUM_REQ(NR), .ALU_LATENCY(2)) dut (
      .clock_in (clk),
      .reset_in (rst_n),
      .bus      (bus.slave),
      .busy_out (busy_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Per-requester stimulus, packed onto the bus.
   logic       rv [NR];
   logic [2:0] ro [NR];
   logic [7:0] ra [NR];
   logic [7:0] rb [NR];
   logic       rr [NR];

   always_comb begin
      for (int i = 0; i < NR; i++) begin
         bus.req_valid_in[i]        = rv[i];
         bus.req_opcode_in[3*i +: 3] = ro[i];
         bus.req_a_in[8*i +: 8]      = ra[i];
         bus.req_b_in[8*i +: 8]      = rb[i];
         bus.resp_ready_in[i]        = rr[i];
      end
   end

   // ALU stub: one register stage, result visible in the second enable cycle.
   function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      p = 16'(a) * 16'(b);
      case (op)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return p[7:0];
         3'd3:    return (a == b) ? 8'd1 : 8'd0;
         3'd4:    return (a > b) ? 8'd1 : 8'd0;
         default: return 8'h00;
      endcase
   endfunction

   logic [7:0] alu_q = 8'h00;
   always @(posedge clk) if (bus.alu_enable_out) alu_q <= alu_f(bus.alu_opcode_out, bus.alu_input1_out, bus.alu_input2_out);
   assign bus.alu_result_in = alu_q;

   typedef struct {
      int         idx;
      logic [7:0] d;
      logic       e;
      int         start;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   en_cnt = 0;
   int   resp_cnt = 0;
   int   hs_cyc = 0;
   bit   in_resp = 0;
   int   start_cyc = 0;

   // Monitor: pop and compare on every response handshake.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (bus.alu_enable_out) en_cnt++;
         if (bus.resp_valid_out == '0) begin
            in_resp = 0;
         end else begin
            if (!in_resp) begin
               in_resp   = 1;
               start_cyc = cyc;
            end
            if ((bus.resp_valid_out & bus.resp_ready_in) != '0) begin
               in_resp = 0;
               hs_cyc  = cyc;
               resp_cnt++;
               n_vec++;
               if (sb.size() == 0) begin
                  n_err++;
                  $display("FAIL unexpected_resp: valid=%b data=%h required no response", bus.resp_valid_out, bus.resp_data_out);
               end else begin
                  e = sb.pop_front();
                  if (bus.resp_valid_out !== (NR'(1) << e.idx) || bus.resp_data_out !== e.d || bus.resp_error_out !== e.e) begin
                     n_err++;
                     $display("FAIL resp_req%0d: valid=%b data=%h err=%b required valid=%b data=%h err=%b",
                              e.idx, bus.resp_valid_out, bus.resp_data_out, bus.resp_error_out,
                              NR'(1) << e.idx, e.d, e.e);
                  end
                  n_vec++;
                  if (start_cyc != e.start) begin
                     n_err++;
                     $display("FAIL resp_latency_req%0d: first valid cycle=%0d required=%0d", e.idx, start_cyc, e.start);
                  end
               end
            end
         end
      end
   end

   // Present a request and wait (bounded) for its acceptance.
   task automatic issue(input int k, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp_d, input logic exp_e, input bit push, output int acc);
      bit got;
      int tries;
      exp_t e;
      got   = 0;
      tries = 0;
      acc   = -1;
      @(negedge clk);
      rv[k] = 1'b1;
      ro[k] = op;
      ra[k] = a;
      rb[k] = b;
      while (!got && tries < 60) begin
         #1;
         if (bus.req_ready_out[k]) begin
            got = 1;
            acc = cyc;
            n_vec++;
            if (bus.req_ready_out !== (NR'(1) << k)) begin
               n_err++;
               $display("FAIL ready_onehot_req%0d: ready=%b required=%b", k, bus.req_ready_out, NR'(1) << k);
            end
            if (push) begin
               e.idx   = k;
               e.d     = exp_d;
               e.e     = exp_e;
               e.start = cyc + ((op > 3'd4) ? 1 : 3);
               sb.push_back(e);
            end
         end else begin
            @(negedge clk);
            tries++;
         end
      end
      if (!got) begin
         n_vec++;
         n_err++;
         $display("FAIL accept_timeout_req%0d: ready never high, required acceptance", k);
      end
      @(posedge clk);
      #1;
      rv[k] = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((sb.size() != 0 || in_resp) && t < 100) begin
         @(negedge clk);
         #3;
         t++;
      end
      if (t >= 100) begin
         n_vec++;
         n_err++;
         $display("FAIL drain_timeout: %0d responses outstanding, required 0", sb.size());
      end
   endtask

   task automatic check_zero(input string nm);
      logic [37:0] v;
      v = {bus.req_ready_out, bus.resp_valid_out, bus.resp_data_out, bus.resp_error_out,
           bus.alu_enable_out, bus.alu_opcode_out, bus.alu_input1_out, bus.alu_input2_out, busy_out};
      n_vec++;
      if (v !== '0) begin
         n_err++;
         $display("FAIL %s: outputs=%h required 0", nm, v);
      end
   endtask

   task automatic check_int(input string nm, input int act, input int req);
      n_vec++;
      if (act != req) begin
         n_err++;
         $display("FAIL %s: got %0d required %0d", nm, act, req);
      end
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin : main
      int acc [NR];
      int acc_a, acc_b, en0, rc0;

      for (int i = 0; i < NR; i++) begin
         rv[i] = 1'b1;
         ro[i] = 3'd0;
         ra[i] = 8'h00;
         rb[i] = 8'h00;
         rr[i] = 1'b1;
      end

      // Reset held with every request valid: everything stays 0.
      repeat (3) @(negedge clk);
      #1 check_zero("reset_held");
      for (int i = 0; i < NR; i++) rv[i] = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1 check_zero("after_release");

      // All four requesters together: mul, grants 0..3 every 4 cycles.
      fork
         issue(0, 3'd2, 8'd3, 8'd5, 8'h0F, 1'b0, 1'b1, acc[0]);
         issue(1, 3'd2, 8'd4, 8'd5, 8'h14, 1'b0, 1'b1, acc[1]);
         issue(2, 3'd2, 8'd5, 8'd5, 8'h19, 1'b0, 1'b1, acc[2]);
         issue(3, 3'd2, 8'd6, 8'd5, 8'h1E, 1'b0, 1'b1, acc[3]);
      join
      drain();
      for (int k = 1; k < NR; k++) check_int($sformatf("rr_grant_cycle_req%0d", k), acc[k] - acc[0], 4 * k);

      // Single add from requester 2: wraps, enable exactly 2 cycles.
      en0 = en_cnt;
      issue(2, 3'd0, 8'hF0, 8'h20, 8'h10, 1'b0, 1'b1, acc_a);
      drain();
      check_int("enable_cycles_add", en_cnt - en0, 2);

      // Illegal opcode from requester 1: error response, ALU untouched.
      en0 = en_cnt;
      issue(1, 3'd6, 8'h55, 8'hAA, 8'h00, 1'b1, 1'b1, acc_a);
      drain();
      check_int("enable_cycles_illegal", en_cnt - en0, 0);

      // Response back-pressure on requester 0 while requester 3 waits.
      rr[0] = 1'b0;
      issue(0, 3'd4, 8'd3, 8'd9, 8'h00, 1'b0, 1'b1, acc_a);
      fork
         issue(3, 3'd0, 8'd1, 8'd2, 8'h03, 1'b0, 1'b1, acc_b);
         begin
            int t;
            t = 0;
            @(negedge clk);
            #1;
            while (!bus.resp_valid_out[0] && t < 20) begin
               @(negedge clk);
               #1;
               t++;
            end
            for (int i = 0; i < 5; i++) begin
               n_vec++;
               if ({bus.resp_valid_out, bus.resp_data_out, bus.resp_error_out, bus.req_ready_out} !== {4'b0001, 8'h00, 1'b0, 4'b0000}) begin
                  n_err++;
                  $display("FAIL hold_cycle%0d: valid=%b data=%h err=%b ready=%b required 0001/00/0/0000",
                           i, bus.resp_valid_out, bus.resp_data_out, bus.resp_error_out, bus.req_ready_out);
               end
               @(negedge clk);
               #1;
            end
            rr[0] = 1'b1;
         end
      join
      check_int("accept_after_hold", acc_b, hs_cyc + 1);
      drain();

      // Reset in the middle of EXEC: no response, outputs 0, resubmit works.
      rc0 = resp_cnt;
      issue(1, 3'd1, 8'd0, 8'd1, 8'h00, 1'b0, 1'b0, acc_a);
      rst_n = 1'b0;
      #1 check_zero("reset_mid_exec");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      #3 check_zero("idle_after_abort");
      check_int("no_resp_after_abort", resp_cnt, rc0);
      issue(1, 3'd1, 8'd0, 8'd1, 8'hFF, 1'b0, 1'b1, acc_a);
      drain();

      // Requester 3 granted, then pointer wraps so 0 beats 3.
      issue(3, 3'd0, 8'h10, 8'h05, 8'h15, 1'b0, 1'b1, acc_a);
      drain();
      fork
         issue(3, 3'd1, 8'd9, 8'd4, 8'h05, 1'b0, 1'b1, acc_b);
         issue(0, 3'd2, 8'd2, 8'd3, 8'h06, 1'b0, 1'b1, acc_a);
      join
      check_int("wrap_req0_first", acc_b - acc_a, 4);
      drain();

      repeat (3) @(negedge clk);
      check_int("scoreboard_empty", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one `alu` instance between NUM_REQ independent requesters.
- Each requester submits an opcode and two 8-bit operands with a valid/ready handshake. The block grants requesters round-robin, sequences the ALU for its fixed latency, captures the result and returns it with a response handshake.
- Sits between the requester units and the single ALU; it is the only driver of the ALU's enable, opcode and operand inputs.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ALU_LATENCY, 2, cycles from ALU inputs stable with enable high to alu_output valid (>=1).

Ports:
- clock_in  input  1  system clock, rising edge.
- reset_in  input  1  asynchronous, active-low reset.
- req_valid_in  input  NUM_REQ  request valid, one bit per requester.
- req_ready_out  output  NUM_REQ  request accepted, one-hot or zero.
- req_opcode_in  input  3*NUM_REQ  packed opcodes; requester k uses bits [3k+2:3k].
- req_a_in  input  8*NUM_REQ  packed operand 1; requester k uses bits [8k+7:8k].
- req_b_in  input  8*NUM_REQ  packed operand 2; same packing as req_a_in.
- resp_valid_out  output  NUM_REQ  response valid, one-hot or zero.
- resp_ready_in  input  NUM_REQ  response consumed.
- resp_data_out  output  8  result, shared by all requesters.
- resp_error_out  output  1  opcode was illegal; qualified by resp_valid_out.
- alu_enable_out  output  1  to ALU enable_in.
- alu_opcode_out  output  3  to ALU opcode_in.
- alu_input1_out  output  8  to ALU alu_input1.
- alu_input2_out  output  8  to ALU alu_input2.
- alu_result_in  input  8  from ALU alu_output.
- busy_out  output  1  high in any state other than IDLE.

Behaviour:
- States: IDLE, EXEC, RESP.
- Reset (reset_in low, asynchronous):
  - state goes to IDLE; round-robin pointer goes to 0; latched opcode, operands, result, error flag and latency counter all clear to 0.
  - All outputs are 0 while reset is held, and remain 0 after release until the first request.
  - Reset mid-EXEC or mid-RESP abandons the operation: no response is issued and the requester must resubmit.
- IDLE:
  - Winner = first requester with req_valid_in high, searching from pointer upward and wrapping modulo NUM_REQ.
  - req_ready_out[winner] is combinationally high in that cycle; all other ready bits are low. No valid bits high means no ready bits high.
  - On the handshake (valid & ready), latch the winner index, opcode, a and b.
  - Legal opcode (0..4): next state EXEC, latency counter loads ALU_LATENCY-1.
  - Illegal opcode (5..7): next state RESP with error=1 and result=0. The ALU is never enabled for it.
- EXEC:
  - alu_enable_out=1; alu_opcode_out, alu_input1_out and alu_input2_out hold the latched values.
  - The counter decrements each cycle. In the cycle the counter is 0, capture alu_result_in into the result register and go to RESP.
  - EXEC lasts exactly ALU_LATENCY cycles.
  - Outside EXEC, alu_enable_out=0 and the ALU input outputs are driven to 0.
- RESP:
  - resp_valid_out[granted]=1; resp_data_out=result; resp_error_out=error flag. These hold stable until resp_ready_in[granted] is high.
  - On that cycle: go to IDLE, set pointer = (granted+1) mod NUM_REQ, clear the error flag.
  - resp_ready_in bits of other requesters are ignored.
- Timing:
  - Request accepted at cycle T; resp_valid_out first high at T+ALU_LATENCY+1. Back-to-back throughput is one operation per ALU_LATENCY+2 cycles.
  - Illegal opcode: response valid at T+1.
- Fairness: a requester that holds valid is granted within NUM_REQ grants.
- Boundary conditions:
  - req_valid_in changes in EXEC or RESP are ignored; ready stays low.
  - A requester may hold valid high through its own RESP. It is re-arbitrated in IDLE at lower priority.
  - Pointer wraps from NUM_REQ-1 to 0.
  - Results are ALU outputs truncated to 8 bits, unmodified: add/sub wrap, mul keeps low byte, compares give 0 or 1.

Test Plan:
- Single request, requester 2: opcode 0, a=8'hF0, b=8'h20. Required: ready[2] high in the accept cycle; enable high for exactly 2 cycles; resp_valid_out=4'b0100 with data 8'h10 at T+3; error=0.
- All four requesters valid simultaneously with opcode 2, a=k+3, b=5, resp_ready held high. Required: grants in order 0,1,2,3; data 8'h0F, 8'h14, 8'h19, 8'h1E; one response every 4 cycles.
- Requester 1 sends opcode 6. Required: ALU enable never asserted; resp_valid_out[1] and resp_error_out high at T+1; data 0.
- Requester 0 sends opcode 4, a=3, b=9, with resp_ready_in[0] low for 5 cycles. Required: resp_valid_out and resp_data_out=0 stay stable throughout; a valid from requester 3 in that window is not accepted until the cycle after the response handshake.
- Reset pulled low mid-EXEC (opcode 1, a=0, b=1). Required: all outputs 0 immediately; no response issued; after release, resubmission returns 8'hFF.
- Requester 3 granted, then requesters 0 and 3 both valid. Required: pointer has wrapped to 0, so requester 0 is granted next.
